// File: rtl/hls_snn_izikevich_deadlock_report_ctrl.sv
// Deadlock report controller: qualifies the monitor's block flag, snapshots blocked AXIS channels
// and hands one report per confirmed event to the status path. Optional macro: HLS_SNN_DEADLOCK_TIMESTAMP_EN.
module hls_snn_izikevich_deadlock_report_ctrl #(
    parameter int NUM_AXIS       = 6,
    parameter int NUM_INST       = 4,
    parameter int PERSIST_CYCLES = 16,
    parameter int CNT_W          = 16,
    parameter int TS_W           = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block_in,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic                clear,
    output logic                deadlock_det,
    output logic                deadlock_pulse,
    output logic [NUM_AXIS-1:0] axis_snapshot,
    output logic [CNT_W-1:0]    event_count,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [TS_W-1:0]     report_ts
);

    localparam int PW = $clog2(PERSIST_CYCLES + 1);
    localparam logic [PW-1:0] LAST_CNT = PW'(PERSIST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WATCH   = 3'd1,
        CONFIRM = 3'd2,
        REPORT  = 3'd3,
        LATCHED = 3'd4
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       persist_cnt_q;
    logic                det_q;
    logic                pulse_q;
    logic [NUM_AXIS-1:0] snapshot_q;
    logic [CNT_W-1:0]    event_count_q;
    logic                valid_q;

    logic                design_idle_s;
    assign design_idle_s = &inst_idle_sigs;

`ifdef HLS_SNN_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp; wraps naturally at 2^TS_W
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q <= {TS_W{1'b0}};
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
        end
    end

    assign report_ts = ts_q;
`else
    assign report_ts = {TS_W{1'b0}};
`endif

    // Qualification FSM with all report outputs registered; clear outranks a pending confirmation
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            persist_cnt_q <= {PW{1'b0}};
            det_q         <= 1'b0;
            pulse_q       <= 1'b0;
            snapshot_q    <= {NUM_AXIS{1'b0}};
            event_count_q <= {CNT_W{1'b0}};
            valid_q       <= 1'b0;
`ifdef HLS_SNN_DEADLOCK_TIMESTAMP_EN
            ts_q          <= {TS_W{1'b0}};
`endif
        end else if (clear) begin
            state_q       <= IDLE;
            persist_cnt_q <= {PW{1'b0}};
            det_q         <= 1'b0;
            pulse_q       <= 1'b0;
            snapshot_q    <= {NUM_AXIS{1'b0}};
            valid_q       <= 1'b0;
`ifdef HLS_SNN_DEADLOCK_TIMESTAMP_EN
            ts_q          <= {TS_W{1'b0}};
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (block_in && !design_idle_s) begin
                        state_q       <= WATCH;
                        persist_cnt_q <= PW'(1);
                    end else begin
                        persist_cnt_q <= {PW{1'b0}};
                    end
                end
                WATCH: begin
                    if (!block_in || design_idle_s) begin
                        state_q       <= IDLE;
                        persist_cnt_q <= {PW{1'b0}};
                    end else if (persist_cnt_q == LAST_CNT) begin
                        state_q       <= CONFIRM;
                        persist_cnt_q <= {PW{1'b0}};
                    end else begin
                        persist_cnt_q <= persist_cnt_q + PW'(1);
                    end
                end
                CONFIRM: begin
                    state_q    <= REPORT;
                    snapshot_q <= axis_block_sigs;
                    pulse_q    <= 1'b1;
                    det_q      <= 1'b1;
                    valid_q    <= 1'b1;
                    if (event_count_q != {CNT_W{1'b1}}) begin
                        event_count_q <= event_count_q + CNT_W'(1);
                    end else begin
                        event_count_q <= event_count_q;
                    end
`ifdef HLS_SNN_DEADLOCK_TIMESTAMP_EN
                    ts_q <= ts_cnt_q;
`endif
                end
                REPORT: begin
                    if (report_ready) begin
                        valid_q <= 1'b0;
                        state_q <= LATCHED;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                LATCHED: begin
                    // Re-arm only once the monitor releases block
                    if (!block_in) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= LATCHED;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    persist_cnt_q <= {PW{1'b0}};
                end
            endcase
        end
    end

    assign deadlock_det   = det_q;
    assign deadlock_pulse = pulse_q;
    assign axis_snapshot  = snapshot_q;
    assign event_count    = event_count_q;
    assign report_valid   = valid_q;

endmodule
